// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: address/instruction widths, the halt word, the fetch state enum
// and the packed queue entry {pc, instr}.
package ifq_pkg;

    localparam int IFQ_AW = 11;
    localparam int IFQ_IW = 32;

    // All-ones word terminates fetch when halt detection is built in.
    localparam logic [IFQ_IW-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } ifq_state_e;

    typedef struct packed {
        logic [IFQ_AW-1:0] pc;
        logic [IFQ_IW-1:0] instr;
    } ifq_entry_t;

    // Sequential fetch address; the 11-bit word space wraps 2047 -> 0.
    function automatic logic [IFQ_AW-1:0] pc_inc(input logic [IFQ_AW-1:0] pc);
        return pc + 11'd1;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch queue storage: DEPTH entries, circular read/write pointers.
// Latency: a push is visible at the head on the next cycle; head is combinational.
// Backpressure: push refused when full unless a pop happens the same cycle.
//
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_flush          empties the queue at the next edge (wins over push/pop)
//   i_push/_dat      write one entry at the tail
//   i_pop            retire the head entry
//   o_head_dat       head entry, all zeros when empty
//   o_empty          queue holds no entries
//   o_occupancy      current entry count, 0..DEPTH
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 43
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_dat,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head_dat,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    assign o_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    // A full queue can still take a push when the head leaves in the same cycle.
    assign w_push_ok   = i_push & ~i_flush & (~w_full | i_pop);
    assign w_pop_ok    = i_pop & ~i_flush & ~o_empty;
    assign o_occupancy = r_count;
    assign o_head_dat  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Payload storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: drives imem, buffers returned words, feeds decode.
// Latency: fetch issue to if_valid is 2 cycles; redirect to target valid is 3.
// Backpressure: stops issuing when queue + in-flight would exceed DEPTH after this cycle's pop.
//
// Ports:
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   o_imem_addr, o_imem_oen     word address and active-low read enable
//   i_imem_rdata                read data, one cycle after o_imem_oen=0
//   o_if_valid/_instr/_pc       head instruction towards decode (zeros when empty)
//   i_if_ready                  decode takes the head this cycle
//   i_redirect, i_redirect_pc   taken branch/jump: flush and refetch at target
//   o_fetch_halted              fetch stopped on the halt word
//   o_occupancy                 queue entry count
// Build option: define IFQ_HALT_DETECT_EN to stop fetching after an all-ones word.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [IFQ_AW-1:0] RESET_PC = 11'd0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    output logic [IFQ_AW-1:0]       o_imem_addr,
    output logic                    o_imem_oen,
    input  logic [IFQ_IW-1:0]       i_imem_rdata,
    output logic                    o_if_valid,
    output logic [IFQ_IW-1:0]       o_if_instr,
    output logic [IFQ_AW-1:0]       o_if_pc,
    input  logic                    i_if_ready,
    input  logic                    i_redirect,
    input  logic [IFQ_AW-1:0]       i_redirect_pc,
    output logic                    o_fetch_halted,
    output logic [$clog2(DEPTH):0]  o_occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifq_state_e        r_state;
    logic [IFQ_AW-1:0] r_fetch_pc;
    logic              r_inflight;
    logic [IFQ_AW-1:0] r_inflight_pc;
    logic [IFQ_AW-1:0] r_last_addr;

    ifq_entry_t        w_push_ent;
    ifq_entry_t        w_head_ent;
    logic              w_empty;
    logic [CW-1:0]     w_occ;
    logic              w_pop;
    logic              w_push;
    logic [CW:0]       w_proj;
    logic              w_room;
    logic              w_issue;

    // A redirect cancels the pop: the head belongs to the abandoned path.
    assign w_pop = ~w_empty & i_if_ready & ~i_redirect;

`ifdef IFQ_HALT_DETECT_EN
    logic r_fetch_halted;
    logic w_halt_hit;

    // Once halted, a response already in flight lies past the halt word.
    assign w_push     = r_inflight & ~i_redirect & (r_state == RUN);
    assign w_halt_hit = w_push & (i_imem_rdata == HALT_WORD);
    assign o_fetch_halted = r_fetch_halted;
`else
    assign w_push         = r_inflight & ~i_redirect;
    assign o_fetch_halted = 1'b0;
`endif

    // Entries held once this cycle's pop and the arriving response settle.
    // The pop is only counted when an entry exists, so this never underflows.
    assign w_proj  = {1'b0, w_occ} - {{CW{1'b0}}, w_pop} + {{CW{1'b0}}, r_inflight};
    assign w_room  = (w_proj < (CW + 1)'(DEPTH));
    // Gating with reset keeps the read enable idle while reset is held.
    assign w_issue = i_rst_n & ~i_redirect & (r_state == RUN) & w_room;

    assign o_imem_oen  = ~w_issue;
    assign o_imem_addr = w_issue ? r_fetch_pc : r_last_addr;

    assign w_push_ent.pc    = r_inflight_pc;
    assign w_push_ent.instr = i_imem_rdata;

    ifq_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(ifq_entry_t))
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_redirect),
        .i_push      (w_push),
        .i_push_dat  (w_push_ent),
        .i_pop       (w_pop),
        .o_head_dat  (w_head_ent),
        .o_empty     (w_empty),
        .o_occupancy (w_occ)
    );

    assign o_if_valid  = ~w_empty;
    assign o_if_instr  = w_head_ent.instr;
    assign o_if_pc     = w_head_ent.pc;
    assign o_occupancy = w_occ;

    // Fetch control and run/halt state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= RUN;
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_last_addr   <= '0;
`ifdef IFQ_HALT_DETECT_EN
            r_fetch_halted <= 1'b0;
`endif
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_last_addr   <= r_fetch_pc;
                r_fetch_pc    <= pc_inc(r_fetch_pc);
            end
            // Redirect never coincides with an issue, so it owns r_fetch_pc here.
            if (i_redirect) begin
                r_fetch_pc <= i_redirect_pc;
                r_state    <= RUN;
`ifdef IFQ_HALT_DETECT_EN
                r_fetch_halted <= 1'b0;
            end else if (w_halt_hit) begin
                r_state        <= HALTED;
                r_fetch_halted <= 1'b1;
`endif
            end
        end
    end

endmodule
